// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Instruction-memory request/ready handshake between IF and imem.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : IF stage - PC, imem handshake, IF/ID register, HLT detection.
//            Define FETCH_STATS_EN to add fetch_count/flush_count outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        stall,
    input  wire logic        redirect,
    input  wire logic [15:0] redirect_pc,
    fetch_stage_if.master    imem,
    output logic      [15:0] if_id_instr,
    output logic      [15:0] if_id_pc_plus2,
    output logic             if_id_valid,
`ifdef FETCH_STATS_EN
    output logic      [15:0] fetch_count,
    output logic      [15:0] flush_count,
`endif
    output logic             halted
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        hold_valid_q, hold_valid_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [15:0] hold_pc2_q, hold_pc2_d;
    logic        drop_pending_q, drop_pending_d;
    logic [15:0] target_q, target_d;

    logic        req;
    logic [15:0] pc_plus2;

    // The hold buffer owns the next IF/ID slot, so no new fetch while it is full.
    assign req            = (state_q == ST_FETCH) && !hold_valid_q;
    assign pc_plus2       = pc_q + 16'd2;
    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;

    assign if_id_instr    = instr_q;
    assign if_id_pc_plus2 = pc2_q;
    assign if_id_valid    = valid_q;
    assign halted         = halted_q;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        pc2_d          = pc2_q;
        valid_d        = valid_q;
        halted_d       = halted_q;
        hold_valid_d   = hold_valid_q;
        hold_instr_d   = hold_instr_q;
        hold_pc2_d     = hold_pc2_q;
        drop_pending_d = drop_pending_q;
        target_d       = target_q;

        if (redirect) begin
            instr_d      = NOP_INSTR;
            pc2_d        = 16'h0000;
            valid_d      = 1'b0;
            hold_valid_d = 1'b0;
            state_d      = ST_FETCH;
            halted_d     = 1'b0;
            // An in-flight request cannot be withdrawn; its response is dropped later.
            if (!req || imem.imem_ready) begin
                pc_d           = redirect_pc;
                drop_pending_d = 1'b0;
            end else begin
                target_d       = redirect_pc;
                drop_pending_d = 1'b1;
            end
        end else if (state_q == ST_FETCH) begin
            if (drop_pending_q) begin
                if (imem.imem_ready) begin
                    pc_d           = target_q;
                    drop_pending_d = 1'b0;
                end
            end else if (hold_valid_q) begin
                if (!stall) begin
                    instr_d      = hold_instr_q;
                    pc2_d        = hold_pc2_q;
                    valid_d      = 1'b1;
                    hold_valid_d = 1'b0;
                    if (hold_instr_q[15:12] == 4'hF) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                end
            end else if (imem.imem_ready) begin
                pc_d = pc_plus2;
                if (!stall) begin
                    instr_d = imem.imem_rdata;
                    pc2_d   = pc_plus2;
                    valid_d = 1'b1;
                    if (imem.imem_rdata[15:12] == 4'hF) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                end else begin
                    hold_instr_d = imem.imem_rdata;
                    hold_pc2_d   = pc_plus2;
                    hold_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_FETCH;
            pc_q           <= RESET_PC;
            instr_q        <= NOP_INSTR;
            pc2_q          <= 16'h0000;
            valid_q        <= 1'b0;
            halted_q       <= 1'b0;
            hold_valid_q   <= 1'b0;
            hold_instr_q   <= NOP_INSTR;
            hold_pc2_q     <= 16'h0000;
            drop_pending_q <= 1'b0;
            target_q       <= 16'h0000;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            pc2_q          <= pc2_d;
            valid_q        <= valid_d;
            halted_q       <= halted_d;
            hold_valid_q   <= hold_valid_d;
            hold_instr_q   <= hold_instr_d;
            hold_pc2_q     <= hold_pc2_d;
            drop_pending_q <= drop_pending_d;
            target_q       <= target_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] fetch_count_q, fetch_count_d;
    logic [15:0] flush_count_q, flush_count_d;
    logic        fetch_evt;
    logic        flush_evt;

    assign fetch_evt = !redirect && (state_q == ST_FETCH) && !drop_pending_q
                       && !hold_valid_q && imem.imem_ready;
    assign flush_evt = redirect && (valid_q || hold_valid_q);

    always_comb begin
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        if (fetch_evt && (fetch_count_q != 16'hFFFF)) fetch_count_d = fetch_count_q + 16'd1;
        if (flush_evt && (flush_count_q != 16'hFFFF)) flush_count_d = flush_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= 16'h0000;
            flush_count_q <= 16'h0000;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage with an IF/ID scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [15:0] fetch_count;
    logic [15:0] flush_count;
`endif

    fetch_stage_if imem_bus ();

    fetch_stage #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus.master),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
`ifdef FETCH_STATS_EN
        .fetch_count    (fetch_count),
        .flush_count    (flush_count),
`endif
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_seen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // IF/ID changes are matched against words the memory delivered, in order.
    task automatic monitor_ifid();
        logic [31:0] cur;
        cur = {if_id_instr, if_id_pc_plus2};
        if (!if_id_valid) begin
            last_seen = 32'hFFFF_FFFF;
        end else if (cur !== last_seen) begin
            if (sb_q.size() == 0) begin
                check_val("ifid_unexpected", cur, 32'hFFFF_FFFF);
            end else begin
                check_val("ifid_entry", cur, sb_q.pop_front());
            end
            last_seen = cur;
        end
    endtask

    // One clock: drive inputs, check the combinational request, clock, then monitor.
    task automatic tick(input logic t_rst, input logic t_stall, input logic t_redir,
                        input logic [15:0] t_rpc, input logic t_rdy, input logic [15:0] t_rdata,
                        input logic t_push, input logic exp_req, input logic [15:0] exp_addr);
        rst                 = t_rst;
        stall               = t_stall;
        redirect            = t_redir;
        redirect_pc         = t_rpc;
        imem_bus.imem_ready = t_rdy;
        imem_bus.imem_rdata = t_rdata;
        #1;
        check_val("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, exp_req});
        if (exp_req) check_val("imem_addr", {16'd0, imem_bus.imem_addr}, {16'd0, exp_addr});
        if (t_push) sb_q.push_back({t_rdata, exp_addr + 16'd2});
        @(posedge clk);
        #1;
        monitor_ifid();
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
        check_val({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check_val({tag, "_instr"}, {16'd0, if_id_instr}, 32'h0000);
        check_val({tag, "_pc2"}, {16'd0, if_id_pc_plus2}, 32'h0000);
    endtask

    initial begin
        last_seen           = 32'hFFFF_FFFF;
        rst                 = 1'b1;
        stall               = 1'b0;
        redirect            = 1'b0;
        redirect_pc         = 16'h0000;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 16'h0000;
        @(posedge clk);
        #1;
        tick(1, 0, 0, 16'h0, 0, 16'h0, 0, 1, 16'h0000);
        check_reset_state("rst0");

        // zero-wait fetch of three words
        tick(0, 0, 0, 16'h0, 1, 16'h0123, 1, 1, 16'h0000);
        tick(0, 0, 0, 16'h0, 1, 16'h1456, 1, 1, 16'h0002);
        tick(0, 0, 0, 16'h0, 1, 16'h2789, 1, 1, 16'h0004);
        check_val("zw_last_pc2", {16'd0, if_id_pc_plus2}, 32'h0006);

        // restart, then two wait states at 0x0004
        tick(1, 0, 0, 16'h0, 0, 16'h0, 0, 1, 16'h0006);
        check_reset_state("rst1");
        tick(0, 0, 0, 16'h0, 1, 16'h1000, 1, 1, 16'h0000);
        tick(0, 0, 0, 16'h0, 1, 16'h1002, 1, 1, 16'h0002);
        tick(0, 0, 0, 16'h0, 0, 16'hDEAD, 0, 1, 16'h0004);
        check_val("wait_hold_pc2", {16'd0, if_id_pc_plus2}, 32'h0004);
        tick(0, 0, 0, 16'h0, 0, 16'hDEAD, 0, 1, 16'h0004);
        tick(0, 0, 0, 16'h0, 1, 16'h3004, 1, 1, 16'h0004);
        check_val("wait_pc2", {16'd0, if_id_pc_plus2}, 32'h0006);
        tick(0, 0, 0, 16'h0, 1, 16'h4006, 1, 1, 16'h0006);

        // stall for three cycles while the word at 0x0008 returns
        tick(0, 1, 0, 16'h0, 1, 16'h8123, 1, 1, 16'h0008);
        check_val("stall_ifid_pc2", {16'd0, if_id_pc_plus2}, 32'h0008);
        tick(0, 1, 0, 16'h0, 1, 16'hBAD0, 0, 0, 16'h0000);
        tick(0, 1, 0, 16'h0, 1, 16'hBAD1, 0, 0, 16'h0000);
        check_val("stall_ifid_instr", {16'd0, if_id_instr}, 32'h4006);
        tick(0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0000);
        check_val("unstall_instr", {16'd0, if_id_instr}, 32'h8123);
        check_val("unstall_pc2", {16'd0, if_id_pc_plus2}, 32'h000A);
        tick(0, 0, 0, 16'h0, 1, 16'h500A, 1, 1, 16'h000A);

        // redirect while the request at 0x000C is waiting
        tick(0, 0, 0, 16'h0, 0, 16'h0, 0, 1, 16'h000C);
        tick(0, 0, 1, 16'h0040, 0, 16'h0, 0, 1, 16'h000C);
        check_val("redir_valid", {31'd0, if_id_valid}, 32'd0);
        tick(0, 0, 0, 16'h0, 1, 16'h6666, 0, 1, 16'h000C);
        check_val("drop_valid", {31'd0, if_id_valid}, 32'd0);
        // redirect coinciding with ready discards that word and jumps at once
        tick(0, 0, 1, 16'h0010, 1, 16'h7777, 0, 1, 16'h0040);
        check_val("redir2_valid", {31'd0, if_id_valid}, 32'd0);

        // HLT at 0x0010
        tick(0, 0, 0, 16'h0, 1, 16'hF000, 1, 1, 16'h0010);
        check_val("hlt_halted", {31'd0, halted}, 32'd1);
        check_val("hlt_instr", {16'd0, if_id_instr}, 32'hF000);
        tick(0, 0, 0, 16'h0, 1, 16'hBAD2, 0, 0, 16'h0000);
        tick(0, 0, 0, 16'h0, 1, 16'hBAD3, 0, 0, 16'h0000);
        check_val("hlt_stays", {31'd0, halted}, 32'd1);
        tick(0, 0, 1, 16'h0020, 0, 16'h0, 0, 0, 16'h0000);
        check_val("resume_halted", {31'd0, halted}, 32'd0);
        check_val("resume_valid", {31'd0, if_id_valid}, 32'd0);
        tick(0, 0, 0, 16'h0, 1, 16'h9020, 1, 1, 16'h0020);
        check_val("resume_pc2", {16'd0, if_id_pc_plus2}, 32'h0022);

        // reset in the middle of a wait
        tick(0, 0, 0, 16'h0, 0, 16'h0, 0, 1, 16'h0022);
        tick(1, 0, 0, 16'h0, 0, 16'h0, 0, 1, 16'h0022);
        check_reset_state("rst_wait");

        // reset in the middle of a stall with the hold buffer full
        tick(0, 1, 0, 16'h0, 1, 16'hA000, 0, 1, 16'h0000);
        tick(1, 1, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0000);
        check_reset_state("rst_stall");
        tick(0, 0, 0, 16'h0, 0, 16'h0, 0, 1, 16'h0000);
        check_val("post_rst_valid", {31'd0, if_id_valid}, 32'd0);

        check_val("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
